uart_mem_bridge: RTL
====================

// Module: uart_mem_bridge
// PURPOSE
//  SoC-side initiator of the UART memory protocol. Converts picorv32 native memory requests into
//  byte frames for the UART transmitter, then collects the response bytes from the UART receiver.
//  Sits between the core and the uart_tx/uart_rx pair inside icesugar.
//  The bench-side memory server (recv_word/send_word) is the responder.
// PARAMETERS
//  TimeoutCycles  2000000  clk cycles allowed between response bytes before abort (>=2)
//  TimeoutRdata   32'hDEAD_BEEF  mem_rdata_o returned on timeout/bad ack
// PORTS
//  clk_i          in   1   single system clock
//  reset_i        in   1   synchronous, active-high reset
//  mem_valid_i    in   1   core request valid; held with fields stable until mem_ready_o
//  mem_addr_i     in   32  byte address
//  mem_wdata_i    in   32  write data
//  mem_wstrb_i    in   4   byte strobes; 4'b0000 = read
//  mem_ready_o    out  1   one-cycle completion pulse
//  mem_rdata_o    out  32  read data, valid when mem_ready_o=1
//  tx_data_o      out  8   byte to uart_tx
//  tx_valid_o     out  1   byte valid; held with tx_data_o stable until tx_ready_i
//  tx_ready_i     in   1   uart_tx accepts byte when tx_valid_o & tx_ready_i
//  rx_data_i      in   8   byte from uart_rx
//  rx_valid_i     in   1   rx byte valid
//  rx_ready_o     out  1   bridge consumes byte when rx_valid_i & rx_ready_o
//  err_o          out  1   sticky error (timeout or bad ack); cleared only by reset
// BEHAVIOUR
//  Reset: state IDLE; mem_ready_o=0, mem_rdata_o=0, tx_valid_o=0, tx_data_o=0, rx_ready_o=1, err_o=0,
//   byte/timeout counters 0. Reset mid-frame abandons it; no completion pulse.
//  Frame (all multi-byte fields little-endian):
//   read : tx OP_READ(8'h00), addr[7:0]..addr[31:24]; rx 4 data bytes -> rdata[7:0] first.
//   write: tx {4'h1,wstrb}, addr 4 bytes, wdata 4 bytes; rx 1 byte, must equal ACK(8'hA5).
//  FSM: IDLE -> SEND_OP -> SEND_ADDR -> (SEND_DATA if write) -> RECV_DATA(read)/RECV_ACK(write) -> DONE -> IDLE.
//   IDLE: on mem_valid_i latch addr/wdata/wstrb, go SEND_OP next cycle. rx bytes in IDLE are consumed and dropped.
//   SEND_*: tx_valid_o=1; advance byte index only on handshake; 2-bit index wraps 3->0 on leaving state.
//   RECV_*: rx_ready_o=1, tx_valid_o=0; each accepted byte resets timeout counter.
//   DONE: mem_ready_o=1 for exactly one cycle, mem_rdata_o=assembled word (reads) or 0 (writes).
//  Timeout: counter runs only in RECV_*; reaching TimeoutCycles-1 without a byte -> err_o=1,
//   mem_rdata_o=TimeoutRdata, go DONE (core never hangs). Bad ack byte: err_o=1, go DONE, rdata 0.
//  Simultaneous: rx byte on the same cycle counter expires -> byte wins, no timeout.
//  mem_valid_i low during frame is ignored (protocol violation; frame completes).
//  Latency (zero-wait tx/rx): read = 1 + 5 tx + 4 rx + 1 cycles; write = 1 + 9 tx + 1 rx + 1.
//  Back-to-back: IDLE may accept next request the cycle after DONE.
// STRUCTURE
//  Package uart_mem_pkg: OP_READ, OP_WRITE_HI(4'h1), ACK byte, state_e enum, FRAME field widths.
//  Single module; no sub-module. uart_tx/uart_rx instantiated by parent (icesugar).
// TESTING
//  Read addr 32'h0000_0104, responder returns 11 22 33 44 -> tx 00 04 01 00 00; rdata 32'h4433_2211, one ready pulse.
//  Write addr 32'h2000_0000, wdata 32'hCAFE_F00D, wstrb 4'b0011, ack A5 -> tx 13 00 00 00 20 0D F0 FE CA; ready, err_o=0.
//  tx_ready_i toggling every other cycle -> same byte sequence, tx_data_o stable while stalled.
//  Read, responder sends 2 bytes then stops (TimeoutCycles=50) -> ready after 50 idle cycles, rdata DEADBEEF, err_o=1.
//  Write with ack 8'h5A -> ready pulse, err_o=1 sticky across next good read.
//  reset_i asserted after 3 tx bytes -> outputs at reset values, next read frame starts with 00.

Source files
------------

// File: rtl/uart_mem_pkg.sv
// Shared constants, state encoding and byte-lane helper for the UART memory bridge.
// Frame fields are little-endian; 2-bit indices select the byte within a word.
package uart_mem_pkg;

    localparam logic [7:0] OP_READ       = 8'h00;
    localparam logic [3:0] OP_WRITE_HI   = 4'h1;
    localparam logic [7:0] ACK_BYTE      = 8'hA5;
    localparam logic [1:0] LAST_BYTE_IDX = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_OP   = 3'd1,
        ST_SEND_ADDR = 3'd2,
        ST_SEND_DATA = 3'd3,
        ST_RECV_DATA = 3'd4,
        ST_RECV_ACK  = 3'd5,
        ST_DONE      = 3'd6
    } state_e;

    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    word_byte = word[7:0];
            2'd1:    word_byte = word[15:8];
            2'd2:    word_byte = word[23:16];
            default: word_byte = word[31:24];
        endcase
    endfunction

endpackage

// File: rtl/uart_mem_bridge.sv
// Initiator side of the UART memory protocol: turns a core memory request into a tx byte
// frame and collects the rx response, with a per-byte timeout so the core never hangs.
module uart_mem_bridge
    import uart_mem_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 2000000,
    parameter logic [31:0] TimeoutRdata  = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_rdata_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        err_o
);

    localparam int CNT_W = $clog2(TimeoutCycles);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TimeoutCycles - 1);

    state_e            r_state;
    logic [1:0]        r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [23:0]       r_acc;
    logic              r_mem_ready;
    logic [31:0]       r_mem_rdata;
    logic [7:0]        r_tx_data;
    logic              r_tx_valid;
    logic              r_rx_ready;
    logic              r_err;

    logic w_tx_fire;
    logic w_rx_fire;
    logic w_is_write;
    logic w_cnt_expired;

    assign w_tx_fire     = r_tx_valid & tx_ready_i;
    assign w_rx_fire     = rx_valid_i & r_rx_ready;
    assign w_is_write    = |r_wstrb;
    assign w_cnt_expired = (r_cnt == CNT_LAST);

    assign mem_ready_o = r_mem_ready;
    assign mem_rdata_o = r_mem_rdata;
    assign tx_data_o   = r_tx_data;
    assign tx_valid_o  = r_tx_valid;
    assign rx_ready_o  = r_rx_ready;
    assign err_o       = r_err;

    // Frame sequencer; all outputs are registered alongside the state transitions.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_idx       <= 2'd0;
            r_cnt       <= '0;
            r_addr      <= 32'h0000_0000;
            r_wdata     <= 32'h0000_0000;
            r_wstrb     <= 4'h0;
            r_acc       <= 24'h00_0000;
            r_mem_ready <= 1'b0;
            r_mem_rdata <= 32'h0000_0000;
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_rx_ready  <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_mem_ready <= 1'b0;
                    if (mem_valid_i) begin
                        r_addr     <= mem_addr_i;
                        r_wdata    <= mem_wdata_i;
                        r_wstrb    <= mem_wstrb_i;
                        r_idx      <= 2'd0;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= (mem_wstrb_i == 4'h0) ? OP_READ : {OP_WRITE_HI, mem_wstrb_i};
                        r_rx_ready <= 1'b0;
                        r_state    <= ST_SEND_OP;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SEND_OP: begin
                    if (w_tx_fire) begin
                        r_tx_data <= word_byte(r_addr, 2'd0);
                        r_state   <= ST_SEND_ADDR;
                    end else begin
                        r_state <= ST_SEND_OP;
                    end
                end
                ST_SEND_ADDR: begin
                    if (w_tx_fire && (r_idx == LAST_BYTE_IDX)) begin
                        r_idx <= 2'd0;
                        if (w_is_write) begin
                            r_tx_data <= word_byte(r_wdata, 2'd0);
                            r_state   <= ST_SEND_DATA;
                        end else begin
                            r_tx_valid <= 1'b0;
                            r_rx_ready <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= ST_RECV_DATA;
                        end
                    end else if (w_tx_fire) begin
                        r_idx     <= r_idx + 2'd1;
                        r_tx_data <= word_byte(r_addr, r_idx + 2'd1);
                    end else begin
                        r_state <= ST_SEND_ADDR;
                    end
                end
                ST_SEND_DATA: begin
                    if (w_tx_fire && (r_idx == LAST_BYTE_IDX)) begin
                        r_idx      <= 2'd0;
                        r_tx_valid <= 1'b0;
                        r_rx_ready <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= ST_RECV_ACK;
                    end else if (w_tx_fire) begin
                        r_idx     <= r_idx + 2'd1;
                        r_tx_data <= word_byte(r_wdata, r_idx + 2'd1);
                    end else begin
                        r_state <= ST_SEND_DATA;
                    end
                end
                // A byte arriving on the expiry cycle takes priority over the timeout.
                ST_RECV_DATA: begin
                    if (w_rx_fire) begin
                        r_cnt <= '0;
                        r_acc <= {rx_data_i, r_acc[23:8]};
                        if (r_idx == LAST_BYTE_IDX) begin
                            r_idx       <= 2'd0;
                            r_mem_rdata <= {rx_data_i, r_acc};
                            r_mem_ready <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end else if (w_cnt_expired) begin
                        r_cnt       <= '0;
                        r_idx       <= 2'd0;
                        r_err       <= 1'b1;
                        r_mem_rdata <= TimeoutRdata;
                        r_mem_ready <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RECV_ACK: begin
                    if (w_rx_fire) begin
                        r_cnt       <= '0;
                        r_err       <= r_err | (rx_data_i != ACK_BYTE);
                        r_mem_rdata <= 32'h0000_0000;
                        r_mem_ready <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (w_cnt_expired) begin
                        r_cnt       <= '0;
                        r_err       <= 1'b1;
                        r_mem_rdata <= TimeoutRdata;
                        r_mem_ready <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_mem_ready <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_mem_ready <= 1'b0;
                    r_tx_valid  <= 1'b0;
                    r_rx_ready  <= 1'b1;
                    r_idx       <= 2'd0;
                    r_cnt       <= '0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
